// File: rtl/stepphase_decoder.sv
// Turns the unipolar stepper coil pattern back into a signed position, direction and step strobe.
// It also flags illegal patterns, skipped phases and stalls. Define STEPDEC_HALFSTEP_EN to decode the 8-phase half-step sequence.
module stepphase_decoder #(
  parameter int POS_WIDTH     = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int STALL_CYCLES  = 400000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [3:0]                  coil_in,
  input  logic                        clear,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        dir,
  output logic                        step_pulse,
  output logic                        illegal,
  output logic                        skip_err,
  output logic                        locked,
  output logic                        stalled
);
`ifdef STEPDEC_HALFSTEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif
  localparam int CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t             state;
  logic [3:0]         syncA, syncB, candidate, curPat;
  logic [CNT_W-1:0]   stableCnt;
  logic [STALL_W-1:0] stallCnt;
  logic [IDX_W-1:0]   phaseIdx, newIdx, delta;
  logic               newLegal, accept, stepFwd, stepBwd, lockEvent;

  always_comb begin
    newIdx   = '0;
    newLegal = 1'b1;
    case (candidate)
`ifdef STEPDEC_HALFSTEP_EN
      4'b1000: newIdx = 3'd0;
      4'b1100: newIdx = 3'd1;
      4'b0100: newIdx = 3'd2;
      4'b0110: newIdx = 3'd3;
      4'b0010: newIdx = 3'd4;
      4'b0011: newIdx = 3'd5;
      4'b0001: newIdx = 3'd6;
      4'b1001: newIdx = 3'd7;
`else
      4'b1100: newIdx = 2'd0;
      4'b0110: newIdx = 2'd1;
      4'b0011: newIdx = 2'd2;
      4'b1001: newIdx = 2'd3;
`endif
      default: newLegal = 1'b0;
    endcase
  end

  // The candidate has matched the synchronized input for STABLE_CYCLES further samples when the counter sits at its last value.
  assign accept    = (syncB == candidate) && (stableCnt == CNT_LAST) && (candidate != curPat);
  assign delta     = newIdx - phaseIdx;
  assign stepFwd   = (delta == IDX_W'(1));
  assign stepBwd   = (delta == '1);
  assign lockEvent = accept && newLegal && (state == UNLOCKED);
  assign locked    = (state == LOCKED);
  assign stalled   = (stallCnt == STALL_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= UNLOCKED;
      syncA      <= '0;
      syncB      <= '0;
      candidate  <= '0;
      curPat     <= '0;
      stableCnt  <= '0;
      stallCnt   <= '0;
      phaseIdx   <= '0;
      position   <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      illegal    <= 1'b0;
      skip_err   <= 1'b0;
    end else begin
      syncA      <= coil_in;
      syncB      <= syncA;
      step_pulse <= 1'b0;

      if (syncB != candidate) begin
        candidate <= syncB;
        stableCnt <= '0;
      end else if (stableCnt != CNT_LAST) begin
        stableCnt <= stableCnt + CNT_W'(1);
      end

      if (step_pulse || lockEvent)
        stallCnt <= '0;
      else if (stallCnt != STALL_MAX)
        stallCnt <= stallCnt + STALL_W'(1);

      // Flag-setting events below override the clear of the flags.
      if (clear) begin
        position <= '0;
        illegal  <= 1'b0;
        skip_err <= 1'b0;
      end

      if (accept) begin
        curPat <= candidate;
        if (!newLegal) begin
          illegal <= 1'b1;
          state   <= UNLOCKED;
        end else if (state == UNLOCKED) begin
          phaseIdx <= newIdx;
          state    <= LOCKED;
        end else begin
          phaseIdx <= newIdx;
          if (stepFwd) begin
            step_pulse <= 1'b1;
            dir        <= 1'b1;
            if (!clear) position <= position + POS_WIDTH'(1);
          end else if (stepBwd) begin
            step_pulse <= 1'b1;
            dir        <= 1'b0;
            if (!clear) position <= position - POS_WIDTH'(1);
          end else begin
            skip_err <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_stepphase_decoder.sv
// Directed bench for stepphase_decoder (full-step build, POS_WIDTH=4, STABLE_CYCLES=4, STALL_CYCLES=20).
module tb_stepphase_decoder;
  logic       clock;
  logic       reset;
  logic [3:0] coilIn;
  logic       clear;
  logic signed [3:0] position;
  logic dir, stepPulse, illegal, skipErr, locked, stalled;

  int tests = 0;
  int failures = 0;
  int pulseCount = 0;
  int pulseSnap;

  stepphase_decoder #(.POS_WIDTH(4), .STABLE_CYCLES(4), .STALL_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .coil_in(coilIn), .clear(clear),
    .position(position), .dir(dir), .step_pulse(stepPulse), .illegal(illegal),
    .skip_err(skipErr), .locked(locked), .stalled(stalled)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (stepPulse === 1'b1) pulseCount++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    coilIn = p;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [3:0] fwdSeq [4];

  initial begin
    fwdSeq[0] = 4'b1100; fwdSeq[1] = 4'b0110; fwdSeq[2] = 4'b0011; fwdSeq[3] = 4'b1001;
    reset = 1'b0; coilIn = 4'b0000; clear = 1'b0;
    edges(3);
    chk("rst_position", $unsigned(position), 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", stepPulse, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_skip", skipErr, 0);
    chk("rst_locked", locked, 0);
    chk("rst_stalled", stalled, 0);
    reset = 1'b1;

    // Lock on 1100 without counting a step
    hold(4'b1100, 10);
    chk("lock_locked", locked, 1);
    chk("lock_position", $unsigned(position), 0);
    chk("lock_pulses", pulseCount, 0);

    // Exact latency of the first forward step: edge E0+6
    hold(4'b0110, 6);
    chk("lat_before", stepPulse, 0);
    edges(1);
    chk("lat_pulse", stepPulse, 1);
    chk("lat_position", $unsigned(position), 1);
    edges(1);
    chk("lat_pulse_drop", stepPulse, 0);
    hold(4'b0110, 0);
    hold(4'b0011, 8);
    hold(4'b1001, 8);
    hold(4'b1100, 8);
    chk("fwd_pulses", pulseCount, 4);
    chk("fwd_position", $unsigned(position), 4);
    chk("fwd_dir", dir, 1);

    clear = 1'b1; edges(1); clear = 1'b0;
    chk("clr_position", $unsigned(position), 0);
    chk("clr_locked", locked, 1);

    hold(4'b1001, 8);
    hold(4'b0011, 8);
    chk("rev_position", $unsigned(position), 4'hE);
    chk("rev_dir", dir, 0);
    clear = 1'b1; edges(1); clear = 1'b0;
    chk("rev_clr_position", $unsigned(position), 0);
    chk("rev_clr_locked", locked, 1);
    hold(4'b0110, 8);
    hold(4'b1100, 8);
    chk("rev2_position", $unsigned(position), 4'hE);

    // Glitches of 2 and of STABLE_CYCLES samples must be ignored
    pulseSnap = pulseCount;
    hold(4'b0110, 2);
    hold(4'b1100, 10);
    hold(4'b0110, 4);
    hold(4'b1100, 10);
    chk("glitch_pulses", pulseCount, pulseSnap);
    chk("glitch_position", $unsigned(position), 4'hE);
    chk("glitch_skip", skipErr, 0);

    // Forward from -2 to +7, then wrap to -8
    for (int i = 1; i <= 9; i++) hold(fwdSeq[i % 4], 8);
    chk("wrap_pre", $unsigned(position), 4'h7);
    hold(4'b0011, 8);
    chk("wrap_position", $unsigned(position), 4'h8);
    chk("wrap_dir", dir, 1);

    // Stall counter was zeroed on the edge after the last pulse
    edges(19);
    chk("stall_not_yet", stalled, 0);
    edges(1);
    chk("stall_set", stalled, 1);
    hold(4'b1001, 7);
    chk("stall_step_pulse", stepPulse, 1);
    chk("stall_still", stalled, 1);
    chk("stall_position", $unsigned(position), 4'h9);
    edges(1);
    chk("stall_cleared", stalled, 0);

    // Clear on the same edge as a forward step
    coilIn = 4'b1100;
    edges(6);
    clear = 1'b1;
    edges(1);
    clear = 1'b0;
    chk("clrstep_position", $unsigned(position), 0);
    chk("clrstep_pulse", stepPulse, 1);
    chk("clrstep_dir", dir, 1);
    edges(2);

    // Skip coinciding with clear: the flag still sets
    pulseSnap = pulseCount;
    coilIn = 4'b0011;
    edges(6);
    clear = 1'b1;
    edges(1);
    clear = 1'b0;
    chk("skip_flag", skipErr, 1);
    chk("skip_pulse", stepPulse, 0);
    edges(2);
    chk("skip_pulses", pulseCount, pulseSnap);
    chk("skip_sticky", skipErr, 1);
    clear = 1'b1; edges(1); clear = 1'b0;
    chk("skip_clear", skipErr, 0);

    hold(4'b1001, 8);
    chk("post_skip_position", $unsigned(position), 1);
    hold(4'b1111, 8);
    chk("ill_flag", illegal, 1);
    chk("ill_locked", locked, 0);
    chk("ill_position", $unsigned(position), 1);
    pulseSnap = pulseCount;
    hold(4'b0110, 8);
    chk("relock_locked", locked, 1);
    chk("relock_pulses", pulseCount, pulseSnap);
    chk("relock_illegal", illegal, 1);

    // Asynchronous reset mid-run, no clock edge in between
    hold(4'b1100, 7);
    reset = 1'b0;
    #2;
    chk("arst_position", $unsigned(position), 0);
    chk("arst_illegal", illegal, 0);
    chk("arst_locked", locked, 0);
    chk("arst_dir", dir, 0);
    chk("arst_step", stepPulse, 0);
    chk("arst_stalled", stalled, 0);
    edges(2);
    reset = 1'b1;
    pulseSnap = pulseCount;
    hold(4'b1100, 10);
    chk("resume_locked", locked, 1);
    chk("resume_position", $unsigned(position), 0);
    chk("resume_pulses", pulseCount, pulseSnap);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/stepphase_decoder.md
# stepphase_decoder

Decodes the 4-bit coil-drive pattern of a unipolar stepper back into a signed step position, a direction and a step strobe. It sits on the return path of the stepper drive, tapping the coil pins (or their feedback) so that the design can confirm commanded motion. It also detects illegal patterns, skipped phases and stalls.

## Interface

Parameters:
- POS_WIDTH, 16: width of the signed position counter.
- STABLE_CYCLES, 4: consecutive cycles a synchronized pattern must hold before it is accepted. Minimum 1.
- STALL_CYCLES, 400000: idle cycles without a step before `stalled` asserts (8 ms at 50 MHz).

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- coil_in, input, 4: coil pattern, asynchronous to `clock`.
- clear, input, 1: synchronous clear of `position`, `illegal` and `skip_err`.
- position, output, POS_WIDTH: signed step count, two's complement.
- dir, output, 1: direction of the last counted step. 1 = forward.
- step_pulse, output, 1: one-cycle strobe per counted step.
- illegal, output, 1: sticky; an accepted pattern was not in the sequence.
- skip_err, output, 1: sticky; an accepted pattern jumped more than one phase.
- locked, output, 1: decoder has a valid phase reference.
- stalled, output, 1: no step for STALL_CYCLES cycles.

## Operation

- **Synchronizer:** `coil_in` passes through a 2-flop synchronizer.
- **Stability filter:**
  - A candidate register and counter track the synchronized pattern. On mismatch, the candidate is reloaded and the counter is zeroed.
  - A pattern is accepted when it has matched the candidate for STABLE_CYCLES further cycles and it differs from the current phase pattern.
- **Full-step sequence (forward):** 1100 (index 0) → 0110 (1) → 0011 (2) → 1001 (3) → 1100 (0). All other 12 codes are illegal.
- **FSM states:** UNLOCKED and LOCKED. Reset enters UNLOCKED.
  - **UNLOCKED:** an accepted legal pattern loads the phase index and moves to LOCKED. No step is counted. An accepted illegal pattern sets `illegal` and stays UNLOCKED.
  - **LOCKED:** compute delta = (new − old) mod 4.
    - Delta 1: position + 1, `dir` = 1, `step_pulse`.
    - Delta 3: position − 1, `dir` = 0, `step_pulse`.
    - Delta 2: set `skip_err`. Position and `dir` are unchanged, no pulse, and the phase index is updated.
    - Accepted illegal pattern: set `illegal` and go to UNLOCKED. Position is held.
- **Position wrap:** two's complement wrap. 0x7FFF + 1 gives 0x8000, and 0 − 1 gives 0xFFFF.
- **Stall counter:**
  - Zeroed on `step_pulse` and on the UNLOCKED→LOCKED transition.
  - Otherwise increments and saturates at STALL_CYCLES.
  - `stalled` = 1 while counter == STALL_CYCLES.
- **clear:**
  - Zeroes `position`, `illegal` and `skip_err` on the same edge. FSM, phase index, `dir` and the stall counter are unaffected.
  - If a step is accepted on the same edge, clear wins for position (result is 0). `step_pulse` and `dir` still reflect the step.
  - If a flag-setting event coincides with clear, the flag is set (event wins for flags).
- **Reset values:** `position` 0, `dir` 0, `step_pulse` 0, `illegal` 0, `skip_err` 0, `locked` 0, `stalled` 0, stall counter 0, synchronizer and candidate 0000.

## Timing

- Let E0 be the edge at which the first synchronizer flop captures a new `coil_in` value. `position`, `dir`, `step_pulse` and `locked` update at edge E0 + 2 + STABLE_CYCLES.
- A glitch shorter than STABLE_CYCLES + 1 synchronized samples produces no event.
- `step_pulse` is high for exactly one cycle per step. Back-to-back steps are limited by the filter to at most one per STABLE_CYCLES + 1 cycles.
- `stalled` rises STALL_CYCLES cycles after the last counter zeroing and falls one cycle after the next `step_pulse` edge.
- Reset asserted mid-operation clears everything immediately and asynchronously. After release, the decoder resumes in UNLOCKED.

## Configuration

- **STEPDEC_HALFSTEP_EN defined:** the block decodes the 8-entry half-step sequence 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001 (indices 0–7), with delta taken mod 8.
  - Delta 1 counts +1 and delta 7 counts −1; `position` counts half-steps.
  - Deltas 2–6 set `skip_err`.
  - Illegal set: 0000, 0101, 0111, 1010, 1011, 1101, 1110, 1111.
- **Not defined:** full-step decoding only, as above. Single-coil codes are illegal.

## Test plan

- Reset, then hold 1100 for 10 cycles, then apply 0110, 0011, 1001, 1100, each held 8 cycles → `locked` = 1, four `step_pulse`s, `position` = 4, `dir` = 1.
- From locked at 1100, apply 1001, 0011, each held 8 cycles → `position` = −2 (0xFFFE), `dir` = 0. Then pulse `clear` → `position` = 0, `locked` stays 1.
- Locked at 1100, apply 0110 for 2 cycles, then return to 1100 → no `step_pulse`, `position` unchanged.
- Locked at 1100, apply 0011 → `skip_err` = 1, no pulse. Then apply 1111 → `illegal` = 1, `locked` = 0, `position` held.
- With STALL_CYCLES = 20: lock, make one step, wait 20 cycles → `stalled` = 1. Next step → `stalled` = 0.
- Force position to 0x7FFF via 32767 forward steps (or use a reduced POS_WIDTH = 4 build with 7 steps), then one more forward step → position wraps to the most negative value. Also assert reset mid-run → all outputs return to 0 asynchronously.
